// File: rtl/full_adder_str_half_adder.sv
// Gate-level half adder: the building block of each full-adder cell.
// Two of these plus an OR gate make one bit of the ripple-carry chain.
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/full_adder_str.sv
// Structural ripple-carry adder built from half-adder pairs, with live combinational
// outputs and a registered copy of the same result.
module full_adder_str #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             c0,
  output logic [WIDTH-1:0] s_q,
  output logic             c0_q
);

  logic [WIDTH:0]   k;   // carry chain, k[0] is the external carry-in
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] g2;

  assign k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    half_adder u_ha_gen (
      .x     (a[i]),
      .y     (b[i]),
      .sum   (p[i]),
      .carry (g1[i])
    );

    half_adder u_ha_sum (
      .x     (p[i]),
      .y     (k[i]),
      .sum   (s[i]),
      .carry (g2[i])
    );

    assign k[i+1] = g1[i] | g2[i];
  end

  assign c0 = k[WIDTH];

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; the async clear needs rst_n in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      c0_q <= 1'b0;
    end else begin
      s_q  <= s;
      c0_q <= c0;
    end
  end

endmodule

// File: tb/tb_full_adder_str.sv
// Self-checking bench for full_adder_str: WIDTH=1 truth table, reset and latency,
// then WIDTH=8 ripple boundaries and a random sweep against an arithmetic model.
module tb_full_adder_str;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, c1;
  logic       s1, c0_1, s_q1, c0_q1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8, s_q8;
  logic       c0_8, c0_q8;

  int checks = 0;
  int errors = 0;

  full_adder_str #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a1),
    .b    (b1),
    .c    (c1),
    .s    (s1),
    .c0   (c0_1),
    .s_q  (s_q1),
    .c0_q (c0_q1)
  );

  full_adder_str #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a8),
    .b    (b8),
    .c    (c8),
    .s    (s8),
    .c0   (c0_8),
    .s_q  (s_q8),
    .c0_q (c0_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition of the three operands.
  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int unsigned t;
    t = int'(x) + int'(y) + int'(ci);
    return t[8:0];
  endfunction

  initial begin
    logic [8:0] exp9;
    logic [8:0] exp_q;
    int unsigned tt;

    rst_n = 1'b0;
    {a1, b1, c1} = 3'b000;
    a8 = '0; b8 = '0; c8 = 1'b0;

    // Exhaustive WIDTH=1 truth table, two time units per vector.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, c1} = v;
      tt = int'(v[2]) + int'(v[1]) + int'(v[0]);
      #1;
      check($sformatf("tt_%0d%0d%0d", v[2], v[1], v[0]), 64'({c0_1, s1}), 64'(tt[1:0]));
      #1;
    end

    // Clock edges while held in reset must not load the registers.
    {a1, b1, c1} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_s_q",  64'(s_q1),  64'(0));
      check("rst_hold_c0_q", 64'(c0_q1), 64'(0));
      check("rst_comb_s",    64'(s1),    64'(1));
      check("rst_comb_c0",   64'(c0_1),  64'(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_s_q",  64'(s_q1),  64'(1));
    check("rst_release_c0_q", 64'(c0_q1), 64'(1));

    // Asynchronous clear between edges.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_s_q",  64'(s_q1),  64'(0));
    check("async_rst_c0_q", 64'(c0_q1), 64'(0));
    check("async_rst_comb", 64'({c0_1, s1}), 64'(3));

    // One-cycle latency: 010 then 101.
    @(negedge clk);
    rst_n = 1'b1;
    {a1, b1, c1} = 3'b010;
    @(posedge clk); #1;
    check("lat_010_s_q",  64'(s_q1),  64'(1));
    check("lat_010_c0_q", 64'(c0_q1), 64'(0));
    @(negedge clk);
    {a1, b1, c1} = 3'b101;
    #1;
    check("lat_hold_s_q",  64'(s_q1),  64'(1));
    check("lat_hold_c0_q", 64'(c0_q1), 64'(0));
    @(posedge clk); #1;
    check("lat_101_s_q",  64'(s_q1),  64'(0));
    check("lat_101_c0_q", 64'(c0_q1), 64'(1));

    // WIDTH=8 carry boundaries.
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #1;
    check("ripple_ff_00_1", 64'({c0_8, s8}), 64'(9'h100));
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
    check("ripple_ff_ff_1", 64'({c0_8, s8}), 64'(9'h1FF));
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
    check("zero_00_00_0", 64'({c0_8, s8}), 64'(9'h000));
    a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1; #1;
    check("ripple_a5_5a_1", 64'({c0_8, s8}), 64'(9'h100));

    // Random sweep: combinational sum now, registered copy one edge later.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp9 = ref_sum(a8, b8, c8);
      #1;
      check($sformatf("rand_comb_%0d", i), 64'({c0_8, s8}), 64'(exp9));
      exp_q = exp9;
      @(posedge clk); #1;
      check($sformatf("rand_reg_%0d", i), 64'({c0_q8, s_q8}), 64'(exp_q));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
